// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source: pixel clock-enable, blanking, sync,
// frame_start and RGB from free-running divider plus h/v counters.
module video_timing_gen #(
    parameter int unsigned CE_DIV   = 4,
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 40,
    parameter int unsigned V_ACTIVE = 224,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [1:0]  pattern,
    input  logic [23:0] solid_rgb,
    output logic        pix_ce,
    output logic        hblank,
    output logic        vblank,
    output logic        hs,
    output logic        vs,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pat_q, pat_d;
    logic [23:0]   solid_q, solid_d;
    logic          pix_ce_q, pix_ce_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;

    logic          tick_c;
    logic          at_origin_c;
    logic          hb_c, vb_c;
    logic [31:0]   h_ext_c, v_ext_c;
    logic [1:0]    pat_eff_c;
    logic [23:0]   solid_eff_c;
    logic [23:0]   bar_rgb_c;
    logic [23:0]   rgb_c;

    // Colour of the pixel being sampled; (0,0) uses the freshly latched pattern
    always_comb begin
        h_ext_c     = 32'(h_cnt_q);
        v_ext_c     = 32'(v_cnt_q);
        at_origin_c = (h_cnt_q == '0) && (v_cnt_q == '0);
        hb_c        = (h_ext_c >= H_ACTIVE);
        vb_c        = (v_ext_c >= V_ACTIVE);
        pat_eff_c   = at_origin_c ? pattern : pat_q;
        solid_eff_c = at_origin_c ? solid_rgb : solid_q;
        // Bar order W,Y,C,G,M,R,B,K maps to R=~idx[1], G=~idx[2], B=~idx[0]
        bar_rgb_c   = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
        case (pat_eff_c)
            2'd0:    rgb_c = solid_eff_c;
            2'd1:    rgb_c = bar_rgb_c;
            2'd2:    rgb_c = ((h_ext_c[3:0] == 4'd0) || (v_ext_c[3:0] == 4'd0))
                             ? 24'hFFFFFF : 24'h000000;
            default: rgb_c = h_ext_c[0] ? 24'h000000 : 24'hFFFFFF;
        endcase
        if (hb_c || vb_c) begin
            rgb_c = '0;
        end
    end

    // Divider, counters and registered outputs
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        tick_c        = (div_d == DIV_LAST);
        pix_ce_d      = tick_c;
        frame_start_d = 1'b0;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        bar_pos_d     = bar_pos_q;
        bar_idx_d     = bar_idx_q;
        pat_d         = pat_q;
        solid_d       = solid_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        rgb_d         = rgb_q;

        if (tick_c) begin
            if (!run) begin
                h_cnt_d   = '0;
                v_cnt_d   = '0;
                bar_pos_d = '0;
                bar_idx_d = '0;
                hblank_d  = 1'b1;
                vblank_d  = 1'b1;
                hs_d      = 1'b0;
                vs_d      = 1'b0;
                rgb_d     = '0;
            end else begin
                if (at_origin_c) begin
                    pat_d         = pattern;
                    solid_d       = solid_rgb;
                    frame_start_d = 1'b1;
                end
                hblank_d = hb_c;
                vblank_d = vb_c;
                hs_d     = (h_ext_c >= H_ACTIVE + H_FP) && (h_ext_c < H_ACTIVE + H_FP + H_SYNC);
                vs_d     = (v_ext_c >= V_ACTIVE + V_FP) && (v_ext_c < V_ACTIVE + V_FP + V_SYNC);
                rgb_d    = rgb_c;

                if (h_ext_c == H_TOTAL - 1) begin
                    h_cnt_d   = '0;
                    bar_pos_d = '0;
                    bar_idx_d = '0;
                    v_cnt_d   = (v_ext_c == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                    if (32'(bar_pos_q) == BAR_W - 1) begin
                        bar_pos_d = '0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_pos_d = bar_pos_q + BW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            bar_pos_q     <= '0;
            bar_idx_q     <= '0;
            pat_q         <= '0;
            solid_q       <= '0;
            pix_ce_q      <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            bar_pos_q     <= bar_pos_d;
            bar_idx_q     <= bar_idx_d;
            pat_q         <= pat_d;
            solid_q       <= solid_d;
            pix_ce_q      <= pix_ce_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign frame_start = frame_start_q;

endmodule
